// File: rtl/hls_stream_serializer.sv
// Captures NUM_CH ap_fifo-style streams into per-channel FIFOs and drains them round-robin
// onto a narrow bus as framed beats: one header beat (channel index), then payload LSB-first.
module hls_stream_serializer #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  output logic [NUM_CH-1:0]        ch_full_n,
  output logic [OUT_W-1:0]         data_out,
  output logic                     data_valid,
  output logic                     data_last,
  output logic                     probe_out,
  output logic [NUM_CH-1:0]        ovf_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BEATS = DATA_W / OUT_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [BW-1:0] beat_t;
  typedef logic [CW-1:0] ch_t;

  localparam cnt_t  FullCnt  = cnt_t'(DEPTH);
  localparam beat_t LastBeat = beat_t'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_t;

  logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];
  ptr_t              wr_ptr_q [NUM_CH];
  ptr_t              rd_ptr_q [NUM_CH];
  cnt_t              count_q  [NUM_CH];
  logic [NUM_CH-1:0] push, pop;

  state_t            state_q;
  ch_t               last_grant_q;
  logic [DATA_W-1:0] shift_q;
  beat_t             beat_q;

  logic              grant_valid;
  ch_t               grant_idx;
  logic              take;
  logic [DATA_W-1:0] grant_word;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_full_n[i] = (count_q[i] != FullCnt);
      push[i]      = ch_write[i] & ch_full_n[i];
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!grant_valid && count_q[idx] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = ch_t'(idx);
      end
    end
  end

  always_comb begin
    take = grant_valid &&
           ((state_q == StIdle) || (state_q == StData && beat_q == LastBeat));
    pop  = '0;
    if (take) pop[grant_idx] = 1'b1;
    grant_word = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= ch_din[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ovf_err <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + ptr_t'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + ptr_t'(1);
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + cnt_t'(1);
        else if (!push[i] && pop[i]) count_q[i] <= count_q[i] - cnt_t'(1);
        // Full is judged on registered occupancy, so a same-cycle pop does not save the write.
        if (ch_write[i] && !ch_full_n[i]) ovf_err[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      last_grant_q <= ch_t'(NUM_CH - 1);
      shift_q      <= '0;
      beat_q       <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      data_last    <= 1'b0;
      probe_out    <= 1'b0;
    end else begin
      data_out   <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      case (state_q)
        StHdr: begin
          state_q    <= StData;
          beat_q     <= '0;
          data_valid <= 1'b1;
          data_out   <= shift_q[OUT_W-1:0];
          data_last  <= (BEATS == 1);
          shift_q    <= shift_q >> OUT_W;
        end
        StData: begin
          if (beat_q == LastBeat) begin
            state_q   <= StIdle;
            probe_out <= ~probe_out;
          end else begin
            beat_q     <= beat_q + beat_t'(1);
            data_valid <= 1'b1;
            data_out   <= shift_q[OUT_W-1:0];
            data_last  <= ((beat_q + beat_t'(1)) == LastBeat);
            shift_q    <= shift_q >> OUT_W;
          end
        end
        default: ;
      endcase
      // A grant overrides the idle/return path so back-to-back frames have no gap.
      if (take) begin
        state_q      <= StHdr;
        last_grant_q <= grant_idx;
        shift_q      <= grant_word;
        data_valid   <= 1'b1;
        data_out     <= OUT_W'(grant_idx);
        data_last    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hls_stream_serializer.sv
// Directed bench for hls_stream_serializer (NUM_CH=2, DATA_W=32, OUT_W=4, DEPTH=4).
module tb_hls_stream_serializer;

  logic        ap_clk;
  logic        ap_rst;
  logic [1:0]  ch_write;
  logic [63:0] ch_din;
  logic [1:0]  ch_full_n;
  logic [3:0]  data_out;
  logic        data_valid;
  logic        data_last;
  logic        probe_out;
  logic [1:0]  ovf_err;

  hls_stream_serializer #(
    .NUM_CH(2),
    .DATA_W(32),
    .OUT_W (4),
    .DEPTH (4)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ch_write  (ch_write),
    .ch_din    (ch_din),
    .ch_full_n (ch_full_n),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_last (data_last),
    .probe_out (probe_out),
    .ovf_err   (ovf_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int first_c = -1;
  int last_c  = -1;
  int toggles = 0;
  int idle_nz = 0;
  int tw;
  logic probe_prev;
  logic [4:0] beats[$];
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; sample #1 after the edge and log any valid beat as {last, data}.
  task automatic step();
    @(posedge ap_clk);
    #1;
    cyc++;
    if (data_valid) begin
      beats.push_back({data_last, data_out});
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
    end else if (data_out != 4'h0) begin
      idle_nz++;
    end
    if (probe_out != probe_prev) toggles++;
    probe_prev = probe_out;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic clear_mon();
    beats.delete();
    exp_q.delete();
    first_c    = -1;
    last_c     = -1;
    toggles    = 0;
    probe_prev = probe_out;
  endtask

  task automatic do_reset();
    ap_rst   = 1'b1;
    ch_write = 2'b00;
    ch_din   = '0;
    step();
    ap_rst = 1'b0;
    clear_mon();
  endtask

  task automatic add_frame(input int ch, input logic [31:0] w);
    exp_q.push_back({1'b0, 4'(ch)});
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), w[k*4 +: 4]});
  endtask

  task automatic compare_beats(input string tag);
    check({tag, " nbeats"}, 64'(beats.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
      check($sformatf("%s beat%0d", tag, i), 64'(beats[i]), 64'(exp_q[i]));
  endtask

  initial begin
    ap_rst     = 1'b1;
    ch_write   = 2'b00;
    ch_din     = '0;
    probe_prev = 1'b0;
    step();
    do_reset();
    check("rst full_n", 64'(ch_full_n), 64'h3);
    check("rst valid", 64'(data_valid), 64'h0);
    check("rst data", 64'(data_out), 64'h0);
    check("rst last", 64'(data_last), 64'h0);
    check("rst probe", 64'(probe_out), 64'h0);
    check("rst ovf", 64'(ovf_err), 64'h0);

    // Single word on ch0
    ch_write = 2'b01;
    ch_din   = {32'h0, 32'h12345678};
    step();
    tw = cyc;
    ch_write = 2'b00;
    check("single no hdr yet", 64'(data_valid), 64'h0);
    check("single full_n", 64'(ch_full_n), 64'h3);
    step();
    check("single hdr valid", 64'(data_valid), 64'h1);
    check("single hdr data", 64'(data_out), 64'h0);
    drain(12);
    add_frame(0, 32'h12345678);
    compare_beats("single");
    check("single hdr cycle", 64'(first_c), 64'(tw + 1));
    check("single toggles", 64'(toggles), 64'h1);
    check("single probe", 64'(probe_out), 64'h1);

    // Round-robin
    do_reset();
    ch_write = 2'b11;
    ch_din   = {32'h55555555, 32'hAAAAAAAA};
    step();
    ch_din   = {32'h89ABCDEF, 32'h01234567};
    step();
    ch_write = 2'b00;
    drain(45);
    add_frame(0, 32'hAAAAAAAA);
    add_frame(1, 32'h55555555);
    add_frame(0, 32'h01234567);
    add_frame(1, 32'h89ABCDEF);
    compare_beats("rr");
    check("rr contiguous", 64'(last_c - first_c + 1), 64'd36);
    check("rr toggles", 64'(toggles), 64'h4);
    check("rr probe", 64'(probe_out), 64'h0);

    // Overflow on ch1 while ch0 frame streams
    do_reset();
    ch_write = 2'b01;
    ch_din   = {32'h0, 32'h0BADF00D};
    step();
    ch_write = 2'b10;
    for (int i = 0; i < 4; i++) begin
      ch_din = {32'h11110000 + 32'(i), 32'h0};
      step();
      if (i == 2) check("ovf full_n after 3", 64'(ch_full_n), 64'h3);
    end
    check("ovf full_n after 4", 64'(ch_full_n), 64'h1);
    check("ovf clear before drop", 64'(ovf_err), 64'h0);
    ch_din = {32'hDEADBEEF, 32'h0};
    step();
    ch_write = 2'b00;
    check("ovf set", 64'(ovf_err), 64'h2);
    drain(50);
    add_frame(0, 32'h0BADF00D);
    for (int i = 0; i < 4; i++) add_frame(1, 32'h11110000 + 32'(i));
    compare_beats("ovf");
    check("ovf sticky", 64'(ovf_err), 64'h2);

    // Pointer wrap-around with write gaps
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ch_write = 2'b01;
      ch_din   = {32'h0, 32'h13579BDF ^ (32'(i) * 32'h11111111)};
      step();
      ch_write = 2'b00;
      drain(7);
      add_frame(0, 32'h13579BDF ^ (32'(i) * 32'h11111111));
    end
    drain(30);
    compare_beats("wrap");
    check("wrap ovf", 64'(ovf_err), 64'h0);

    // Reset mid-frame with a second word queued
    do_reset();
    ch_write = 2'b01;
    ch_din   = {32'h0, 32'h12345678};
    step();
    ch_din   = {32'h0, 32'hCAFEF00D};
    step();
    ch_write = 2'b00;
    drain(3);
    check("midrst beat3", 64'(data_out), 64'h6);
    ap_rst = 1'b1;
    step();
    check("midrst valid", 64'(data_valid), 64'h0);
    check("midrst data", 64'(data_out), 64'h0);
    check("midrst full_n", 64'(ch_full_n), 64'h3);
    check("midrst last", 64'(data_last), 64'h0);
    ap_rst = 1'b0;
    clear_mon();
    drain(25);
    check("midrst residual", 64'(beats.size()), 64'h0);

    // Push while pop at full
    do_reset();
    ch_write = 2'b01;
    for (int i = 0; i < 5; i++) begin
      ch_din = {32'h0, 32'hC0DE0000 + 32'(i)};
      step();
      add_frame(0, 32'hC0DE0000 + 32'(i));
    end
    ch_write = 2'b00;
    check("pwp full", 64'(ch_full_n), 64'h2);
    check("pwp no ovf yet", 64'(ovf_err), 64'h0);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (data_last) found = 1'b1;
        else step();
      end
      check("pwp wait last", 64'(found), 64'h1);
    end
    ch_write = 2'b01;
    ch_din   = {32'h0, 32'hFFFF0000};
    step();
    ch_write = 2'b00;
    check("pwp ovf", 64'(ovf_err), 64'h1);
    check("pwp full_n after", 64'(ch_full_n), 64'h3);
    drain(50);
    compare_beats("pwp");

    check("idle data zero", 64'(idle_nz), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
